// File: rtl/m_dmem_resp_if.sv
// Request/response bus between the Me-stage requester and the data-memory responder.
interface m_dmem_resp_if;
  logic        w_req_valid;
  logic        w_req_ready;
  logic        w_req_we;
  logic [31:0] w_req_addr;
  logic [31:0] w_req_wdata;
  logic        r_resp_valid;
  logic        w_resp_ready;
  logic [31:0] r_resp_rdata;

  // Requester side (processor Me stage)
  modport master (
    output w_req_valid, w_req_we, w_req_addr, w_req_wdata, w_resp_ready,
    input  w_req_ready, r_resp_valid, r_resp_rdata
  );

  // Responder side (memory)
  modport slave (
    input  w_req_valid, w_req_we, w_req_addr, w_req_wdata, w_resp_ready,
    output w_req_ready, r_resp_valid, r_resp_rdata
  );
endinterface

// File: rtl/m_dmem_resp.sv
// Data-memory responder: single-outstanding word load/store with configurable
// wait states, word-addressed RAM and a memory-mapped LED register.
module m_dmem_resp #(
  parameter int unsigned WAIT_CYC   = 2,
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter logic [31:0] LED_ADDR   = 32'h0000_8000
) (
  input  logic         w_clk,
  input  logic         w_rst_n,
  input  logic         w_ce,
  m_dmem_resp_if.slave bus,
  output logic [31:0]  r_led
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [31:0]         addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic [DATA_W-1:0]   led_q, led_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH_LOG2-1:0] idx_c;
  logic                is_led_c;
  logic                mem_we_c;
  logic [DATA_W-1:0]   mem_rdata_c;

  // Word index of the latched address; higher bits alias, LED compare is full width
  assign idx_c       = addr_q[DEPTH_LOG2+1:2];
  assign is_led_c    = (addr_q == LED_ADDR);
  assign mem_rdata_c = mem[idx_c];

  // Ready only in IDLE, never while reset is asserted or the clock is gated off
  assign bus.w_req_ready  = (state_q == S_IDLE) & w_rst_n & w_ce;
  assign bus.r_resp_valid = resp_valid_q;
  assign bus.r_resp_rdata = resp_rdata_q;
  assign r_led            = led_q;

  // Next-state, request latching and access logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    led_d        = led_q;
    mem_we_c     = 1'b0;

    if (w_ce) begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.w_req_valid) begin
            we_d    = bus.w_req_we;
            addr_d  = bus.w_req_addr;
            wdata_d = bus.w_req_wdata;
            cnt_d   = CNT_W'(WAIT_CYC);
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            // The access itself happens on the WAIT->RESP edge
            if (we_q) begin
              if (is_led_c) begin
                led_d = wdata_q;
              end else begin
                mem_we_c = 1'b1;
              end
              resp_rdata_d = '0;
            end else begin
              resp_rdata_d = is_led_c ? led_q : mem_rdata_c;
            end
            resp_valid_d = 1'b1;
            state_d      = S_RESP;
          end
        end
        S_RESP: begin
          if (bus.w_resp_ready) begin
            resp_valid_d = 1'b0;
            state_d      = S_IDLE;
          end
        end
        default: begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
        end
      endcase
    end
  end

  // Control and output registers; async reset drops any pending access
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      led_q        <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      led_q        <= led_d;
    end
  end

  // RAM write port; contents survive reset
  always_ff @(posedge w_clk) begin
    if (mem_we_c) begin
      mem[idx_c] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_m_dmem_resp.sv
// Scoreboard bench for m_dmem_resp (WAIT_CYC=2, DEPTH_LOG2=12, LED at 0x8000).
module tb_m_dmem_resp;
  localparam logic [31:0] LED = 32'h0000_8000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce;
  logic [31:0] led;

  m_dmem_resp_if bus();

  m_dmem_resp #(
    .WAIT_CYC  (2),
    .DEPTH_LOG2(12),
    .LED_ADDR  (LED)
  ) dut (
    .w_clk  (clk),
    .w_rst_n(rst_n),
    .w_ce   (ce),
    .bus    (bus),
    .r_led  (led)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q [$];
  logic [31:0] model_mem [logic [11:0]];
  logic [31:0] model_led;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: bp = resp_ready-low cycles, ce_hold = ce-low cycles in WAIT
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input int bp, input int ce_hold, input int exp_acc_wait);
    int n;
    int w;
    logic [31:0] led_before;
    logic [31:0] exp;
    logic [31:0] held;
    logic [11:0] i;
    bus.w_req_valid  = 1'b1;
    bus.w_req_we     = we;
    bus.w_req_addr   = addr;
    bus.w_req_wdata  = wdata;
    bus.w_resp_ready = (bp == 0);
    w = 0;
    while (!bus.w_req_ready && w < 50) begin
      tick();
      w++;
    end
    if (w >= 50) check_eq("accept_timeout", 32'(bus.w_req_ready), 32'd1);
    if (exp_acc_wait >= 0) check_eq("accept_wait", 32'(w), 32'(exp_acc_wait));
    tick();
    // Scramble request fields after the handshake; the DUT must hold its copy
    bus.w_req_valid = 1'b0;
    bus.w_req_we    = ~we;
    bus.w_req_addr  = ~addr;
    bus.w_req_wdata = ~wdata;
    i = addr[13:2];
    led_before = model_led;
    if (we) begin
      exp = 32'h0;
      if (addr == LED) model_led = wdata;
      else model_mem[i] = wdata;
    end else if (addr == LED) begin
      exp = model_led;
    end else begin
      exp = model_mem.exists(i) ? model_mem[i] : 32'hxxxx_xxxx;
    end
    exp_q.push_back(exp);
    n = 0;
    while (!bus.r_resp_valid && n < 50) begin
      check_eq("led_early", led, led_before);
      ce = (n >= 1 && n < 1 + ce_hold) ? 1'b0 : 1'b1;
      tick();
      n++;
    end
    ce = 1'b1;
    check_eq("latency", 32'(n), 32'(3 + ce_hold));
    check_eq("rdata", bus.r_resp_rdata, exp_q.pop_front());
    check_eq("led", led, model_led);
    if (bp > 0) begin
      held = bus.r_resp_rdata;
      bus.w_req_valid = 1'b1;
      bus.w_req_we    = 1'b0;
      bus.w_req_addr  = 32'h0000_0100;
      bus.w_req_wdata = 32'h0;
      for (int k = 0; k < bp; k++) begin
        tick();
        check_eq("bp_valid", 32'(bus.r_resp_valid), 32'd1);
        check_eq("bp_rdata", bus.r_resp_rdata, held);
        check_eq("bp_ready", 32'(bus.w_req_ready), 32'd0);
      end
      bus.w_resp_ready = 1'b1;
    end
    tick();
    check_eq("resp_done", 32'(bus.r_resp_valid), 32'd0);
    if (bp > 0) check_eq("ready_after_hs", 32'(bus.w_req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pick [6];
    rst_n = 1'b0;
    ce    = 1'b1;
    bus.w_req_valid  = 1'b0;
    bus.w_req_we     = 1'b0;
    bus.w_req_addr   = 32'h0;
    bus.w_req_wdata  = 32'h0;
    bus.w_resp_ready = 1'b1;
    model_led = 32'h0;
    #12;
    check_eq("rst_valid", 32'(bus.r_resp_valid), 32'd0);
    check_eq("rst_rdata", bus.r_resp_rdata, 32'h0);
    check_eq("rst_led", led, 32'h0);
    check_eq("rst_ready", 32'(bus.w_req_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check_eq("idle_ready", 32'(bus.w_req_ready), 32'd1);

    // Basic store then load
    issue(1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 0, 0, 0);
    issue(1'b0, 32'h0000_0100, 32'h0, 0, 0, 0);

    // LED register write and readback
    issue(1'b1, LED, 32'h0000_002A, 0, 0, -1);
    issue(1'b0, LED, 32'h0, 0, 0, -1);

    // LED address must not touch the RAM word it would otherwise alias to
    issue(1'b1, 32'h0000_0000, 32'h5555_AAAA, 0, 0, -1);
    issue(1'b1, LED, 32'h0000_0077, 0, 0, -1);
    issue(1'b0, 32'h0000_0000, 32'h0, 0, 0, -1);

    // Backpressure; the pending load is accepted on the first edge after the handshake
    issue(1'b0, 32'h0000_0100, 32'h0, 5, 0, -1);
    issue(1'b0, 32'h0000_0100, 32'h0, 0, 0, 0);

    // Reset during WAIT discards a store
    issue(1'b1, 32'h0000_0040, 32'h1111_1111, 0, 0, -1);
    bus.w_req_valid = 1'b1;
    bus.w_req_we    = 1'b1;
    bus.w_req_addr  = 32'h0000_0040;
    bus.w_req_wdata = 32'h2222_2222;
    check_eq("rw_ready", 32'(bus.w_req_ready), 32'd1);
    tick();
    bus.w_req_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("rw_valid", 32'(bus.r_resp_valid), 32'd0);
    check_eq("rw_rdata", bus.r_resp_rdata, 32'h0);
    check_eq("rw_led", led, 32'h0);
    check_eq("rw_ready0", 32'(bus.w_req_ready), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    model_led = 32'h0;
    tick();
    check_eq("rw_valid_after", 32'(bus.r_resp_valid), 32'd0);
    issue(1'b0, 32'h0000_0040, 32'h0, 0, 0, 0);

    // Clock enable low for three cycles inside WAIT
    issue(1'b0, 32'h0000_0040, 32'h0, 0, 3, -1);

    // Alignment bits ignored and 16 KB alias
    issue(1'b1, 32'h0000_4103, 32'hCAFE_F00D, 0, 0, -1);
    issue(1'b0, 32'h0000_0100, 32'h0, 0, 0, -1);

    // Random mix over written/aliased addresses
    pick[0] = 32'h0000_0000;
    pick[1] = 32'h0000_0100;
    pick[2] = 32'h0000_0040;
    pick[3] = LED;
    pick[4] = 32'h0000_4000;
    pick[5] = 32'h0000_4100;
    for (int r = 0; r < 16; r++) begin
      issue(1'($urandom_range(0, 1)), pick[$urandom_range(0, 5)], $urandom, 0,
            int'($urandom_range(0, 1)), -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
